// File: rtl/stage_mem_pkg.sv
// stage_mem_pkg: shared encodings and helpers for the MEM pipeline stage.
//   ld_width_e  : load width codes carried by inflagLoadWordDividerMEM
//   st_width_e  : store width codes carried by inflagStoreWordDividerMEM
//   memtoreg_e  : write-back source select (passed through untouched)
//   store_be()  : byte-lane enables for a store of a given width/offset
package stage_mem_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned LANES  = 4;

  typedef enum logic [2:0] {
    LD_LW  = 3'b000,
    LD_LH  = 3'b001,
    LD_LHU = 3'b010,
    LD_LB  = 3'b011,
    LD_LBU = 3'b100
  } ld_width_e;

  typedef enum logic [1:0] {
    ST_SW  = 2'b00,
    ST_SH  = 2'b01,
    ST_SB  = 2'b10,
    ST_RSV = 2'b11
  } st_width_e;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_MEM  = 2'b01,
    WB_LINK = 2'b10,
    WB_RSV  = 2'b11
  } memtoreg_e;

  // Little-endian lane enables; reserved width writes nothing.
  function automatic logic [LANES-1:0] store_be(input logic [1:0] width,
                                                input logic [1:0] offset);
    logic [LANES-1:0] be;
    be = '0;
    case (st_width_e'(width))
      ST_SW:   be = 4'b1111;
      ST_SH:   be = offset[1] ? 4'b1100 : 4'b0011;
      ST_SB:   be = 4'b0001 << offset;
      default: be = '0;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/data_mem_bytelane.sv
// data_mem_bytelane: DEPTH_WORDS x 32 data RAM, asynchronous read,
// synchronous per-byte write. Contents are not reset.
//   clk     : write clock
//   be      : byte-lane write enables (lane k = bits [8k+7:8k])
//   addr    : word index
//   wdata   : write data, already positioned in its lanes
//   rdata_c : combinational read of the addressed word
module data_mem_bytelane
  import stage_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic [LANES-1:0]  be,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata_c
);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  assign rdata_c = mem[addr];

  // Byte-lane write port
  always_ff @(posedge clk) begin
    for (int k = 0; k < int'(LANES); k++) begin
      if (be[k]) mem[addr][8*k +: 8] <= wdata[8*k +: 8];
    end
  end

endmodule

// File: rtl/stage_mem.sv
// stage_mem: pipeline MEM stage. Performs the data-memory access for the
// instruction in EX/MEM (store lane enables, load extraction/extension,
// alignment check) and registers the result into the MEM/WB latch.
//   in*           : EX/MEM latch fields (control, widths, address, data, rd)
//   inMEM_Flush   : squash the current instruction into a bubble
//   enable        : 0 stalls the stage (latch holds, no memory write)
//   out*          : MEM/WB latch fields; outMisaligned flags an alignment fault
module stage_mem
  import stage_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inMemRead,
  input  logic              inMemWrite,
  input  logic              inRegWrite,
  input  logic [1:0]        inMemtoReg,
  input  logic [2:0]        inflagLoadWordDividerMEM,
  input  logic [1:0]        inflagStoreWordDividerMEM,
  input  logic [DATA_W-1:0] inAlu,
  input  logic [DATA_W-1:0] inDataRt,
  input  logic [REG_W-1:0]  inMuxRtRd,
  input  logic              inMEM_Flush,
  input  logic              enable,
  output logic [DATA_W-1:0] outMemData,
  output logic [DATA_W-1:0] outAlu,
  output logic [REG_W-1:0]  outMuxRtRd,
  output logic [1:0]        outMemtoReg,
  output logic              outRegWrite,
  output logic              outMisaligned
);

  logic [1:0]        offset_c;
  logic [AW-1:0]     word_idx_c;
  logic              ld_mis_c;
  logic              st_mis_c;
  logic              mis_c;
  logic              we_c;
  logic [LANES-1:0]  be_c;
  logic [DATA_W-1:0] st_wdata_c;
  logic [DATA_W-1:0] rdata_c;
  logic [DATA_W-1:0] shifted_c;
  logic [DATA_W-1:0] load_c;

  // Upper address bits are ignored so accesses wrap modulo memory size.
  assign offset_c   = inAlu[1:0];
  assign word_idx_c = inAlu[AW+1:2];

  // Alignment check per access width
  always_comb begin
    ld_mis_c = 1'b0;
    st_mis_c = 1'b0;
    case (ld_width_e'(inflagLoadWordDividerMEM))
      LD_LW:         ld_mis_c = (offset_c != 2'b00);
      LD_LH, LD_LHU: ld_mis_c = offset_c[0];
      default:       ld_mis_c = 1'b0;
    endcase
    case (st_width_e'(inflagStoreWordDividerMEM))
      ST_SW:   st_mis_c = (offset_c != 2'b00);
      ST_SH:   st_mis_c = offset_c[0];
      default: st_mis_c = 1'b0;
    endcase
  end

  assign mis_c = (inMemRead & ld_mis_c) | (inMemWrite & st_mis_c);

  // Store replicates data into every lane; byte enables pick the real ones.
  always_comb begin
    st_wdata_c = inDataRt;
    case (st_width_e'(inflagStoreWordDividerMEM))
      ST_SH:   st_wdata_c = {2{inDataRt[15:0]}};
      ST_SB:   st_wdata_c = {4{inDataRt[7:0]}};
      default: st_wdata_c = inDataRt;
    endcase
  end

  assign we_c = inMemWrite & enable & ~inMEM_Flush & ~mis_c;
  assign be_c = store_be(inflagStoreWordDividerMEM, offset_c) & {LANES{we_c}};

  data_mem_bytelane #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_dmem (
    .clk     (clk),
    .be      (be_c),
    .addr    (word_idx_c),
    .wdata   (st_wdata_c),
    .rdata_c (rdata_c)
  );

  // Bring the addressed lane(s) down to bit 0, then extend.
  assign shifted_c = rdata_c >> {offset_c, 3'b000};

  always_comb begin
    load_c = '0;
    if (inMemRead) begin
      case (ld_width_e'(inflagLoadWordDividerMEM))
        LD_LW:   load_c = rdata_c;
        LD_LH:   load_c = {{16{shifted_c[15]}}, shifted_c[15:0]};
        LD_LHU:  load_c = {16'h0000, shifted_c[15:0]};
        LD_LB:   load_c = {{24{shifted_c[7]}}, shifted_c[7:0]};
        LD_LBU:  load_c = {24'h000000, shifted_c[7:0]};
        default: load_c = '0;
      endcase
    end
  end

  // MEM/WB latch: stall holds, flush inserts a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outMemData    <= '0;
      outAlu        <= '0;
      outMuxRtRd    <= '0;
      outMemtoReg   <= '0;
      outRegWrite   <= 1'b0;
      outMisaligned <= 1'b0;
    end else if (enable) begin
      if (inMEM_Flush) begin
        outMemData    <= '0;
        outAlu        <= '0;
        outMuxRtRd    <= '0;
        outMemtoReg   <= '0;
        outRegWrite   <= 1'b0;
        outMisaligned <= 1'b0;
      end else begin
        outMemData    <= load_c;
        outAlu        <= inAlu;
        outMuxRtRd    <= inMuxRtRd;
        outMemtoReg   <= inMemtoReg;
        outRegWrite   <= inRegWrite & ~mis_c;
        outMisaligned <= mis_c;
      end
    end
  end

endmodule

// File: doc/stage_mem.md
# stage_mem

Pipeline MEM stage: consumes the EX/MEM latch outputs (ALU result, Rt data, destination register, control and load/store width flags), performs data-memory access with byte/halfword lane handling, and registers the result into the MEM/WB latch feeding write-back. Holds the data memory, store byte-enable generation, load extraction/extension, misalignment detection and the MEM/WB pipeline register with stall and flush.

## Interface
Parameters:
- DEPTH_WORDS, 256: data memory depth in 32-bit words (power of two).
- AW, log2(DEPTH_WORDS): word-index width.

Ports:
- clk  in  1  pipeline clock; all state changes on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- inMemRead  in  1  load in MEM.
- inMemWrite  in  1  store in MEM.
- inRegWrite  in  1  instruction writes register file.
- inMemtoReg  in  2  write-back source select, passed through.
- inflagLoadWordDividerMEM  in  3  load width: 000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU.
- inflagStoreWordDividerMEM  in  2  store width: 00 SW, 01 SH, 10 SB, 11 reserved (no write).
- inAlu  in  32  effective address / ALU result.
- inDataRt  in  32  store data.
- inMuxRtRd  in  5  destination register.
- inMEM_Flush  in  1  turn current instruction into a bubble.
- enable  in  1  0 = stall: latch holds, no memory write.
- outMemData  out  32  extended load data (MEM/WB).
- outAlu  out  32  ALU result (MEM/WB).
- outMuxRtRd  out  5  destination register (MEM/WB).
- outMemtoReg  out  2  (MEM/WB).
- outRegWrite  out  1  (MEM/WB).
- outMisaligned  out  1  registered: instruction in WB faulted on alignment.

## Operation
- Word index = inAlu[AW+1:2]; upper address bits ignored (wraps modulo memory size). Byte offset = inAlu[1:0].
- Misaligned: LW/SW with offset≠0; LH/LHU/SH with offset[0]=1. Byte ops never misaligned. Only evaluated when inMemRead or inMemWrite.
- Store: write enabled iff inMemWrite & enable & ~inMEM_Flush & ~misaligned & width≠11. SW: all four lanes ← inDataRt. SH: lanes {offset+1,offset} ← inDataRt[15:0]. SB: lane offset ← inDataRt[7:0]. Little-endian: lane k = bits [8k+7:8k].
- Load: memory read is combinational (asynchronous read). LB/LBU select lane offset, LH/LHU lanes from offset; sign- or zero-extend to 32. LW passes word. Reserved load codes yield 0. Non-load instructions: outMemData captures 0.
- Misaligned access: outRegWrite forced 0 and outMisaligned=1 in the latched instruction; store suppressed.
- MEM/WB latch, priority: rst_n=0 > enable=0 (hold all) > inMEM_Flush=1 (bubble: all outputs 0) > normal capture.
- Memory contents are not reset; reset affects only the latch.

## Timing
- Reset values: outMemData, outAlu=0; outMuxRtRd=0; outMemtoReg=0; outRegWrite=0; outMisaligned=0. Async assert, latch released on first edge after deassert.
- Latency: one cycle MEM→WB; store committed at the same edge that latches the instruction.
- Load following store to same word: store written at edge N, load in MEM at cycle N+1 reads new data (no bypass needed).
- Stall with pending store: no write until the cycle enable=1; write occurs exactly once.
- Flush and stall together: stall wins, latch holds, no write.

## Structure
- Package stage_mem_pkg: load-width codes (LW, LH, LHU, LB, LBU), store-width codes (SW, SH, SB), MemtoReg encodings.
- Sub-module data_mem_bytelane: DEPTH_WORDS×32 RAM, async read, synchronous write with 4-bit byte enable. Lane extraction, alignment check and MEM/WB latch stay in stage_mem.

## Test plan
- Reset mid-run: rst_n low for 1 ns between edges → all outputs 0 immediately; memory content at word 3 preserved.
- SW 0xDEADBEEF to 0x0C, then LW 0x0C → outMemData=0xDEADBEEF one cycle after load enters.
- SB 0x80 to 0x0D then LB 0x0D → 0xFFFFFF80; LBU 0x0D → 0x00000080; LH 0x0C → 0xFFFF80EF.
- SH to 0x0E (word held 0x11223344) with Rt=0x0000ABCD → word 0xABCD3344; LHU 0x0E → 0x0000ABCD.
- SW to 0x0E (misaligned) → memory unchanged, outMisaligned=1, outRegWrite=0; LW 0x401C with DEPTH_WORDS=256 aliases word 7.
- enable=0 for 3 cycles with SW pending → single write after release, outputs held; inMEM_Flush with SW → no write, outputs bubble.
